wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter SP_INIT, default 32'h0000_0100: reset value of register 29 ($sp).
REQ-002 Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- PC_Plus_4  in  32  writeback PC+4, for link writes.
- RF_WD_Src  in  3  writeback data select.
- WE_Reg  in  1  register-file write enable.
- WE_HiLo  in  1  HI/LO write enable.
- R64_Lo  in  32  low word of the 64-bit multiply/divide result.
- R64_Hi  in  32  high word of the 64-bit multiply/divide result.
- RF_WA  in  5  register-file write address.
- ALU_Res  in  32  ALU result.
- RD_DM  in  32  data-memory read data.
- RA1  in  5  read address, port 1.
- RA2  in  5  read address, port 2.
- RA3  in  5  debug read address.
- RD1  out  32  read data, port 1.
- RD2  out  32  read data, port 2.
- RD3  out  32  debug read data.
- WD  out  32  selected writeback data, for the forwarding unit.
- WB_Active  out  1  high when a register-file write commits this cycle.

Function
REQ-003 WD SHALL be combinational, selected by RF_WD_Src:
- 0: ALU_Res
- 1: RD_DM
- 2: PC_Plus_4
- 3: HI
- 4: LO
- 5-7: 32'h0
REQ-004 For codes 3 and 4, HI/LO SHALL be the stored value, or R64_Hi/R64_Lo when WE_HiLo=1 in the same cycle (bypass).
REQ-005 WB_Active SHALL equal WE_Reg AND (RF_WA != 0) AND (RF_WD_Src <= 4), combinationally.
REQ-006 On a rising CLK edge with WB_Active=1, register[RF_WA] SHALL take WD; with WB_Active=0, no register changes.
REQ-007 Register 0 SHALL always read 32'h0; writes to it SHALL be discarded.
REQ-008 Codes 5-7 SHALL suppress the register write, even with WE_Reg=1.
REQ-009 RD1/RD2/RD3 SHALL be combinational reads (zero read latency).
REQ-010 Write-first bypass: when WB_Active=1 and RAx==RF_WA, RDx SHALL return WD in the same cycle, before the edge.
REQ-011 On a rising edge with WE_HiLo=1, HI SHALL take R64_Hi and LO SHALL take R64_Lo, both together; with WE_HiLo=0, both hold.
REQ-012 Simultaneous WE_Reg and WE_HiLo SHALL both commit on the same edge; with RF_WD_Src=3, the register write uses the new R64_Hi (REQ-004).
REQ-013 Write latency SHALL be one edge: data written at edge N is readable without bypass from after edge N.

Reset
REQ-014 While RST=1, all registers except 29 SHALL be 32'h0, register 29 SHALL be SP_INIT, and HI=LO=32'h0, regardless of CLK.
REQ-015 A write presented in a cycle where RST asserts mid-cycle SHALL be lost.
REQ-016 The first write after RST deasserts SHALL commit on the first rising edge with RST=0.
REQ-017 Outputs SHALL remain combinational during reset and reflect the reset state.

Structure
REQ-018 The RF_WD_Src encodings (WB_SRC_ALU=0, WB_SRC_DM=1, WB_SRC_PC4=2, WB_SRC_HI=3, WB_SRC_LO=4) SHALL live in the shared pipeline package, also used by the control decoder.
REQ-019 HI/LO storage SHALL be one sub-module, hilo_reg: CLK, RST, WE, Hi_In, Lo_In, Hi_Out, Lo_Out.
REQ-020 The register array SHALL be 31 x 32-bit flops (register 0 not stored), not an inferred RAM, to permit asynchronous reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: RST pulse -> RD(RA=29)=32'h0000_0100, RD(RA=5)=0, mfhi WD=0.
- Write/readback: WE_Reg=1, RF_WA=8, src=0, ALU_Res=32'hDEAD_BEEF -> RD1(RA1=8) returns DEADBEEF same cycle (bypass) and after the edge.
- Register 0: WE_Reg=1, RF_WA=0, ALU_Res=32'hFFFF_FFFF -> RD1(RA1=0)=0, WB_Active=0.
- HI/LO: WE_HiLo=1, R64_Hi=32'h1, R64_Lo=32'h2, same cycle src=3, RF_WA=9 -> reg9=1; next cycle src=4, RF_WA=10 -> reg10=2.
- Illegal source/link: src=6, WE_Reg=1, RF_WA=4 -> WD=0, reg4 unchanged; src=2, PC_Plus_4=32'h0040_0008, RF_WA=31 -> reg31=0040_0008.
- Async reset mid-run: reg8 written, RST asserted between edges -> RD(RA=8)=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: writeback source encodings and datapath widths.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  // Writeback data select, shared with the control decoder.
  typedef enum logic [2:0] {
    WB_SRC_ALU = 3'd0,
    WB_SRC_DM  = 3'd1,
    WB_SRC_PC4 = 3'd2,
    WB_SRC_HI  = 3'd3,
    WB_SRC_LO  = 3'd4
  } wb_src_e;

  // Codes above LO carry no data and must not write the register file.
  function automatic logic wb_src_legal(input logic [2:0] src);
    return src <= 3'(WB_SRC_LO);
  endfunction

endpackage

// File: rtl/wb_regfile_hilo.sv
// HI/LO result pair for multiply/divide; both halves update together.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [DATA_W-1:0] Hi_In,
  input  logic [DATA_W-1:0] Lo_In,
  output logic [DATA_W-1:0] Hi_Out,
  output logic [DATA_W-1:0] Lo_Out
);

  logic [DATA_W-1:0] hi_q, lo_q;

  // Capture both halves of the 64-bit result on a write, clear on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (WE) begin
      hi_q <= Hi_In;
      lo_q <= Lo_In;
    end
  end

  assign Hi_Out = hi_q;
  assign Lo_Out = lo_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: 31 flop registers ($0 hardwired), HI/LO,
// writeback mux and write-first read bypass on all three read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_0100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] PC_Plus_4,
  input  logic [2:0]        RF_WD_Src,
  input  logic              WE_Reg,
  input  logic              WE_HiLo,
  input  logic [DATA_W-1:0] R64_Lo,
  input  logic [DATA_W-1:0] R64_Hi,
  input  logic [ADDR_W-1:0] RF_WA,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [DATA_W-1:0] RD_DM,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] RA3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  output logic [DATA_W-1:0] WD,
  output logic              WB_Active
);

  logic [DATA_W-1:0] hi_stored, lo_stored;
  logic [DATA_W-1:0] hi_eff, lo_eff;
  logic [DATA_W-1:0] rf_view [NUM_REGS];

  hilo_reg u_hilo (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (WE_HiLo),
    .Hi_In  (R64_Hi),
    .Lo_In  (R64_Lo),
    .Hi_Out (hi_stored),
    .Lo_Out (lo_stored)
  );

  // mfhi/mflo in the same cycle as a HI/LO write see the incoming result.
  assign hi_eff = WE_HiLo ? R64_Hi : hi_stored;
  assign lo_eff = WE_HiLo ? R64_Lo : lo_stored;

  // Writeback data select; unused codes drive zero.
  always_comb begin
    WD = '0;
    case (RF_WD_Src)
      3'(WB_SRC_ALU): WD = ALU_Res;
      3'(WB_SRC_DM):  WD = RD_DM;
      3'(WB_SRC_PC4): WD = PC_Plus_4;
      3'(WB_SRC_HI):  WD = hi_eff;
      3'(WB_SRC_LO):  WD = lo_eff;
      default:        WD = '0;
    endcase
  end

  assign WB_Active = WE_Reg && (RF_WA != '0) && wb_src_legal(RF_WD_Src);

  assign rf_view[0] = '0;

  // One flop register per architectural register so reset can be asynchronous.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (gi == 29) ? SP_INIT : '0;
    logic [DATA_W-1:0] reg_q, reg_d;

    // Load writeback data only when this register is the committed target.
    always_comb begin
      reg_d = reg_q;
      if (WB_Active && (RF_WA == ADDR_W'(gi))) reg_d = WD;
    end

    // Asynchronous reset to the architectural reset value.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) reg_q <= RST_VAL;
      else     reg_q <= reg_d;
    end

    assign rf_view[gi] = reg_q;
  end

  // Write-first bypass; $0 never matches because WB_Active excludes it.
  assign RD1 = (WB_Active && (RA1 == RF_WA)) ? WD : rf_view[RA1];
  assign RD2 = (WB_Active && (RA2 == RF_WA)) ? WD : rf_view[RA2];
  assign RD3 = (WB_Active && (RA3 == RF_WA)) ? WD : rf_view[RA3];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC_Plus_4;
  logic [2:0]  RF_WD_Src;
  logic        WE_Reg;
  logic        WE_HiLo;
  logic [31:0] R64_Lo;
  logic [31:0] R64_Hi;
  logic [4:0]  RF_WA;
  logic [31:0] ALU_Res;
  logic [31:0] RD_DM;
  logic [4:0]  RA1, RA2, RA3;
  logic [31:0] RD1, RD2, RD3, WD;
  logic        WB_Active;

  int tests_run = 0;
  int tests_failed = 0;

  wb_regfile #(.SP_INIT(32'h0000_0100)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PC_Plus_4 (PC_Plus_4),
    .RF_WD_Src (RF_WD_Src),
    .WE_Reg    (WE_Reg),
    .WE_HiLo   (WE_HiLo),
    .R64_Lo    (R64_Lo),
    .R64_Hi    (R64_Hi),
    .RF_WA     (RF_WA),
    .ALU_Res   (ALU_Res),
    .RD_DM     (RD_DM),
    .RA1       (RA1),
    .RA2       (RA2),
    .RA3       (RA3),
    .RD1       (RD1),
    .RD2       (RD2),
    .RD3       (RD3),
    .WD        (WD),
    .WB_Active (WB_Active)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE_Reg = 0; WE_HiLo = 0; RF_WD_Src = 3'd0; RF_WA = 5'd0;
    ALU_Res = 0; RD_DM = 0; PC_Plus_4 = 0; R64_Hi = 0; R64_Lo = 0;
  endtask

  task automatic test_reset();
    idle();
    RA1 = 5'd5; RA2 = 5'd0; RA3 = 5'd29;
    RST = 1'b1;
    #1;
    RF_WD_Src = 3'd3;
    #1;
    tests_run++;
    if (RD3 !== 32'h0000_0100) begin
      tests_failed++; $display("FAIL reset_sp: got %h want %h", RD3, 32'h0000_0100);
    end
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++; $display("FAIL reset_r5: got %h want %h", RD1, 32'h0);
    end
    tests_run++;
    if (WD !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mfhi: got %h want %h", WD, 32'h0);
    end
    tick(); tick();
    RST = 1'b0;
    RF_WD_Src = 3'd0;
    $display("[TB] reset: sp=%h r5=%h", RD3, RD1);
  endtask

  task automatic test_write_readback();
    WE_Reg = 1; RF_WA = 5'd8; RF_WD_Src = 3'd0; ALU_Res = 32'hDEAD_BEEF;
    RA1 = 5'd8; RA2 = 5'd8;
    #1;
    tests_run++;
    if (RD1 !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL wr_bypass: got %h want %h", RD1, 32'hDEAD_BEEF);
    end
    tests_run++;
    if (WB_Active !== 1'b1) begin
      tests_failed++; $display("FAIL wr_active: got %b want 1", WB_Active);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (RD2 !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL wr_stored: got %h want %h", RD2, 32'hDEAD_BEEF);
    end
    $display("[TB] write r8 <- deadbeef, readback %h", RD2);
  endtask

  task automatic test_reg0();
    WE_Reg = 1; RF_WA = 5'd0; RF_WD_Src = 3'd0; ALU_Res = 32'hFFFF_FFFF; RA1 = 5'd0;
    #1;
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++; $display("FAIL r0_bypass: got %h want %h", RD1, 32'h0);
    end
    tests_run++;
    if (WB_Active !== 1'b0) begin
      tests_failed++; $display("FAIL r0_active: got %b want 0", WB_Active);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++; $display("FAIL r0_stored: got %h want %h", RD1, 32'h0);
    end
    $display("[TB] write r0 <- ffffffff, readback %h", RD1);
  endtask

  task automatic test_hilo();
    WE_HiLo = 1; R64_Hi = 32'h1; R64_Lo = 32'h2;
    WE_Reg = 1; RF_WD_Src = 3'd3; RF_WA = 5'd9;
    #1;
    tests_run++;
    if (WD !== 32'h1) begin
      tests_failed++; $display("FAIL hilo_hi_bypass: got %h want %h", WD, 32'h1);
    end
    tick();
    WE_HiLo = 0; R64_Hi = 32'hAAAA_AAAA; R64_Lo = 32'h5555_5555;
    RF_WD_Src = 3'd4; RF_WA = 5'd10;
    #1;
    tests_run++;
    if (WD !== 32'h2) begin
      tests_failed++; $display("FAIL hilo_lo_stored: got %h want %h", WD, 32'h2);
    end
    tick();
    idle();
    RF_WD_Src = 3'd3; RA1 = 5'd9; RA2 = 5'd10;
    #1;
    tests_run++;
    if (RD1 !== 32'h1) begin
      tests_failed++; $display("FAIL hilo_r9: got %h want %h", RD1, 32'h1);
    end
    tests_run++;
    if (RD2 !== 32'h2) begin
      tests_failed++; $display("FAIL hilo_r10: got %h want %h", RD2, 32'h2);
    end
    tests_run++;
    if (WD !== 32'h1) begin
      tests_failed++; $display("FAIL hilo_hi_hold: got %h want %h", WD, 32'h1);
    end
    RF_WD_Src = 3'd0;
    $display("[TB] hilo: r9=%h r10=%h", RD1, RD2);
  endtask

  task automatic test_illegal_link();
    WE_Reg = 1; RF_WA = 5'd4; RF_WD_Src = 3'd0; ALU_Res = 32'h0000_1234;
    tick();
    RF_WD_Src = 3'd6; ALU_Res = 32'h5555_5555; RA1 = 5'd4;
    #1;
    tests_run++;
    if (WD !== 32'h0) begin
      tests_failed++; $display("FAIL illegal_wd: got %h want %h", WD, 32'h0);
    end
    tests_run++;
    if (WB_Active !== 1'b0) begin
      tests_failed++; $display("FAIL illegal_active: got %b want 0", WB_Active);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (RD1 !== 32'h0000_1234) begin
      tests_failed++; $display("FAIL illegal_r4: got %h want %h", RD1, 32'h0000_1234);
    end
    WE_Reg = 1; RF_WA = 5'd31; RF_WD_Src = 3'd2; PC_Plus_4 = 32'h0040_0008;
    tick();
    idle();
    RA2 = 5'd31;
    #1;
    tests_run++;
    if (RD2 !== 32'h0040_0008) begin
      tests_failed++; $display("FAIL link_r31: got %h want %h", RD2, 32'h0040_0008);
    end
    $display("[TB] illegal src r4=%h, link r31=%h", RD1, RD2);
  endtask

  task automatic test_back_to_back();
    WE_Reg = 1; RF_WD_Src = 3'd1; RF_WA = 5'd11; RD_DM = 32'h1111_0000;
    tick();
    RF_WA = 5'd12; RD_DM = 32'h2222_0000; RA1 = 5'd11; RA2 = 5'd12;
    #1;
    tests_run++;
    if (RD1 !== 32'h1111_0000) begin
      tests_failed++; $display("FAIL b2b_r11: got %h want %h", RD1, 32'h1111_0000);
    end
    tests_run++;
    if (RD2 !== 32'h2222_0000) begin
      tests_failed++; $display("FAIL b2b_r12_bypass: got %h want %h", RD2, 32'h2222_0000);
    end
    tick();
    idle();
    RA3 = 5'd12;
    #1;
    tests_run++;
    if (RD3 !== 32'h2222_0000) begin
      tests_failed++; $display("FAIL b2b_r12: got %h want %h", RD3, 32'h2222_0000);
    end
    $display("[TB] back-to-back r11=%h r12=%h", RD1, RD3);
  endtask

  task automatic test_async_reset();
    RA3 = 5'd8; RA1 = 5'd29; RA2 = 5'd7;
    WE_Reg = 1; RF_WA = 5'd7; RF_WD_Src = 3'd0; ALU_Res = 32'h0000_0077;
    #1;
    tests_run++;
    if (RD3 !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL async_pre_r8: got %h want %h", RD3, 32'hDEAD_BEEF);
    end
    #1;
    RST = 1'b1;
    #1;
    tests_run++;
    if (RD3 !== 32'h0) begin
      tests_failed++; $display("FAIL async_r8: got %h want %h", RD3, 32'h0);
    end
    tests_run++;
    if (RD1 !== 32'h0000_0100) begin
      tests_failed++; $display("FAIL async_sp: got %h want %h", RD1, 32'h0000_0100);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (RD2 !== 32'h0) begin
      tests_failed++; $display("FAIL async_lost_r7: got %h want %h", RD2, 32'h0);
    end
    // Release reset mid-cycle; the very next rising edge must take the write.
    RST = 1'b0;
    WE_Reg = 1; RF_WA = 5'd7; ALU_Res = 32'h0000_0099;
    tick();
    idle();
    #1;
    tests_run++;
    if (RD2 !== 32'h0000_0099) begin
      tests_failed++; $display("FAIL post_reset_r7: got %h want %h", RD2, 32'h0000_0099);
    end
    $display("[TB] async reset r8=%h, first write r7=%h", RD3, RD2);
  endtask

  initial begin
    RA1 = 0; RA2 = 0; RA3 = 0;
    RST = 1'b1;
    idle();
    #2;
    test_reset();
    test_write_readback();
    test_reg0();
    test_hilo();
    test_illegal_link();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
